// File: rtl/add_staged_parts_if.sv
// Start/done handshake bundle for the staged wide adder.
// Ports: start, a, b, modulus (requester -> adder); result, done (adder -> requester).
interface add_staged_parts_if #(
    parameter int SIZE = 896
);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] modulus;
    logic [SIZE:0]   result;
    logic            done;

    modport master (
        output start, a, b, modulus,
        input  result, done
    );

    modport slave (
        input  start, a, b, modulus,
        output result, done
    );
endinterface

// File: rtl/add_staged_parts.sv
// Multi-cycle wide adder: one limb of a + b per clock, carry registered between limbs.
// Ports: clk, rst (async, active-high), bus (slave: start/a/b/modulus in, result/done out).
// Optional macro MOD_REDUCE_EN appends a limb-serial reduction of the sum by modulus.
module add_staged_parts #(
    parameter int SIZE  = 896,
    parameter int PARTS = 8
) (
    input logic             clk,
    input logic             rst,
    add_staged_parts_if.slave bus
);
    localparam int L  = SIZE / PARTS;
    localparam int CW = $clog2(PARTS);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        RED
    } state_t;

    state_t          state;
    logic [CW-1:0]   idx;
    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic [SIZE-L-1:0] limbs;
    logic            carry;
    logic [SIZE:0]   result_q;
    logic            done_q;

    logic [L-1:0]    a_lmb;
    logic [L-1:0]    b_lmb;
    logic [L:0]      add_w;
    logic            last;

    always_comb begin
        a_lmb = a_q[int'(idx)*L +: L];
        b_lmb = b_q[int'(idx)*L +: L];
        add_w = {1'b0, a_lmb} + {1'b0, b_lmb} + (L+1)'(carry);
        last  = (idx == CW'(PARTS - 1));
    end

`ifdef MOD_REDUCE_EN
    logic [SIZE-1:0] m_q;
    logic [SIZE:0]   sum_q;
    logic            borrow;
    logic [L-1:0]    m_lmb;
    logic [L:0]      s_top;
    logic [L+1:0]    sub_w;
    logic            use_diff;

    // The top limb of the sum carries the extra carry-out bit, so the
    // subtraction is one bit wider than a limb plus a sign bit.  For inner
    // limbs bit L is the borrow; for the top limb bit L+1 is the final borrow.
    always_comb begin
        m_lmb = m_q[int'(idx)*L +: L];
        s_top = {last & sum_q[SIZE], sum_q[int'(idx)*L +: L]};
        sub_w = {1'b0, s_top} - {2'b0, m_lmb} - (L+2)'(borrow);
        use_diff = sum_q[SIZE] | ~sub_w[L+1];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            limbs    <= '0;
            carry    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b1;
`ifdef MOD_REDUCE_EN
            m_q      <= '0;
            sum_q    <= '0;
            borrow   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
`ifdef MOD_REDUCE_EN
                        m_q <= bus.modulus;
`endif
                        {carry, limbs[L-1:0]} <=
                            {1'b0, bus.a[L-1:0]} + {1'b0, bus.b[L-1:0]};
                        idx    <= CW'(1);
                        done_q <= 1'b0;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (!last) begin
                        {carry, limbs[int'(idx)*L +: L]} <= add_w;
                        idx <= idx + CW'(1);
                    end else begin
`ifdef MOD_REDUCE_EN
                        sum_q  <= {add_w, limbs};
                        borrow <= 1'b0;
                        idx    <= '0;
                        state  <= RED;
`else
                        result_q <= {add_w, limbs};
                        done_q   <= 1'b1;
                        idx      <= '0;
                        state    <= IDLE;
`endif
                    end
                end
`ifdef MOD_REDUCE_EN
                RED: begin
                    if (!last) begin
                        limbs[int'(idx)*L +: L] <= sub_w[L-1:0];
                        borrow <= sub_w[L];
                        idx    <= idx + CW'(1);
                    end else begin
                        // The sum keeps its own carry-out, so a set S[SIZE]
                        // means S >= modulus even if the L+1-bit top borrows.
                        if (use_diff) begin
                            result_q <= {1'b0, sub_w[L-1:0], limbs};
                        end else begin
                            result_q <= {1'b0, sum_q[SIZE-1:0]};
                        end
                        done_q <= 1'b1;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
`endif
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: doc/add_staged_parts.md
Name: add_staged_parts

Overview:
- Multi-cycle wide adder that computes a + b by splitting the operands into PARTS equal limbs.
- Exactly one limb is added per clock, and the carry is registered between limbs.
- It is the additive counterpart of the staged subtractor in the field-arithmetic primitives, and is used by the point-addition and scalar datapaths on the 896-bit intermediates.
- It shares the subtractor's start/done handshake, so sequencers can swap the two blocks.

Parameters:
- SIZE, 896: operand width in bits. Must be divisible by PARTS.
- PARTS, 8: number of limbs. Must be ≥ 2. Limb width is L = SIZE/PARTS.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation. Sampled only when the block is idle.
- a  input  SIZE  addend A, captured on the accepting edge.
- b  input  SIZE  addend B, captured on the accepting edge.
- modulus  input  SIZE  reduction modulus, captured on the accepting edge. Ignored unless MOD_REDUCE_EN is defined.
- result  output  SIZE+1  sum including the carry-out bit, or the reduced sum.
- done  output  1  high while idle or finished; low while busy.

Behaviour:
- Reset (asynchronous) drives the following values:
  - state = IDLE;
  - done = 1;
  - result = 0;
  - the operand registers, limb registers and carry register are all cleared.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever published.
- States: IDLE, then ADD_0 … ADD_{PARTS-1}, implemented as a limb counter plus a mode bit.
- In IDLE with start=1, on the accepting edge E0:
  - latch a, b and modulus into internal registers;
  - compute {carry, limb0} = a[L-1:0] + b[L-1:0];
  - drive done to 0;
  - advance to limb index 1.
- After E0, a/b/modulus may change freely; later limbs use only the latched copies.
- At limb index k (1 ≤ k ≤ PARTS-2): {carry, limb_k} = A_k + B_k + carry, then k increments.
- At the final limb, index PARTS-1, on edge E(PARTS-1):
  - result[SIZE:SIZE-L] = A_top + B_top + carry, an (L+1)-bit value;
  - result[SIZE-L-1:0] = the concatenated limb registers;
  - done goes to 1 and the block returns to IDLE.
- Latency: done is low for exactly PARTS-1 cycles; result and done update together on E(PARTS-1).
- result holds its previous value for the whole computation and changes only on the completion edge.
- start while busy is ignored. It is not queued.
- Back-to-back operation: with start held high, the next operation is accepted on the first edge after done rises. Peak throughput is one operation per PARTS cycles.
- All arithmetic is unsigned with no overflow loss: result = a + b exactly, with result[SIZE] as the carry-out.
- Carry must ripple correctly across every limb boundary, including a full ripple from limb 0 to the carry-out.

Optional Feature:
- Macro: MOD_REDUCE_EN.
- Defined: after the add phase, a reduce phase of PARTS further limb cycles (R_0 … R_{PARTS-1}) runs.
  - It computes diff = S − modulus over SIZE+1 bits, where S is the (SIZE+1)-bit sum, limb by limb with a registered borrow.
  - On the last reduce edge, result is loaded with one of two values:
    - diff, if S[SIZE]=1 or no final borrow occurred;
    - S, otherwise.
  - Either way result[SIZE] = 0.
  - done is low for 2·PARTS−1 cycles.
  - Callers guarantee a, b < modulus; the output is then (a+b) mod modulus.
  - The intermediate sum S is not published to result.
- Undefined: the modulus port is ignored and the reduce states are not generated. Behaviour is exactly as in Behaviour above.

Test Plan:
- Reset then idle: assert rst mid-test → result=0, done=1 immediately. After release with start=0, both hold indefinitely.
- Full carry ripple (SIZE=896, PARTS=8): a=all ones, b=1, pulse start → done low 7 cycles, then result = 1<<896. Check done rises on the same edge as result changes.
- Operand capture and busy-ignore: a=0x5, b=0x3 with start. The next cycle, set a=b=all ones and pulse start again → result=0x8, and the second start has no effect.
- Back-to-back: hold start=1 with a=0x10, b=0x20, then a=0x1, b=0x1 once done rises → two results 0x30 and 0x2, each PARTS cycles apart.
- Reset mid-operation: start at limb 3 and assert rst → done=1, result=0. A subsequent fresh operation completes with the correct sum.
- MOD_REDUCE_EN (SIZE=16, PARTS=4, modulus=0xFFF1), done low 7 cycles in each case:
  - a=0xFFF0, b=0x0005 → result=0x00004;
  - a=0xFFF0, b=0xFFF0 → result=0x0FFEF;
  - a=0x0001, b=0x0002 → result=0x00003.
